// File: rtl/burst_arbiter.sv
// Round-robin arbiter granting one of N requesters a shared port for a whole burst.
// The grant is locked until the granted requester's last beat is accepted; re-arbitration has no bubble.
module burst_arbiter #(
    parameter  int N  = 4,
    localparam int LG = $clog2(N)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [N-1:0]  i_req,
    input  logic [N-1:0]  i_last,
    input  logic          i_ack,
    output logic [N-1:0]  o_gnt,
    output logic [LG-1:0] o_gnt_id,
    output logic          o_gnt_valid,
    output logic          o_busy
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [LG-1:0] gnt_id_q, gnt_id_d;
    logic [LG-1:0] ptr_q, ptr_d;
    logic          gnt_valid_q, gnt_valid_d;

    logic          release_beat;
    logic [LG-1:0] arb_ptr;
    logic [N-1:0]  win_oh;
    logic [LG-1:0] win_id;

    function automatic logic [N-1:0] first_set(input logic [N-1:0] v);
        logic [N-1:0] pre;
        pre[0] = v[0];
        for (int i = 1; i < N; i++) begin
            pre[i] = pre[i-1] | v[i];
        end
        return pre & ~{pre[N-2:0], 1'b0};
    endfunction

    function automatic logic [N-1:0] arb(input logic [N-1:0] req, input logic [LG-1:0] ptr);
        logic [N-1:0] mask;
        logic [N-1:0] m;
        for (int i = 0; i < N; i++) begin
            mask[i] = (i > int'(ptr));
        end
        m = req & mask;
        return (m != '0) ? first_set(m) : first_set(req);
    endfunction

    function automatic logic [LG-1:0] encode(input logic [N-1:0] oh);
        logic [LG-1:0] id;
        id = '0;
        for (int i = 0; i < N; i++) begin
            if (oh[i]) id = id | LG'(i);
        end
        return id;
    endfunction

    // A release hands the pointer to the releasing requester before arbitrating,
    // so it drops to lowest priority in the very same cycle.
    assign release_beat = gnt_valid_q & i_ack & i_last[gnt_id_q];
    assign arb_ptr      = release_beat ? gnt_id_q : ptr_q;
    assign win_oh       = arb(i_req, arb_ptr);
    assign win_id       = encode(win_oh);

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        ptr_d       = ptr_q;
        gnt_valid_d = gnt_valid_q;
        case (state_q)
            IDLE: begin
                if (win_oh != '0) begin
                    gnt_d       = win_oh;
                    gnt_id_d    = win_id;
                    gnt_valid_d = 1'b1;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (release_beat) begin
                    ptr_d = gnt_id_q;
                    if (win_oh != '0) begin
                        gnt_d    = win_oh;
                        gnt_id_d = win_id;
                    end else begin
                        gnt_d       = '0;
                        gnt_id_d    = '0;
                        gnt_valid_d = 1'b0;
                        state_d     = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            ptr_q       <= LG'(N - 1);
            gnt_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            ptr_q       <= ptr_d;
            gnt_valid_q <= gnt_valid_d;
        end
    end

    assign o_gnt       = gnt_q;
    assign o_gnt_id    = gnt_id_q;
    assign o_gnt_valid = gnt_valid_q;
    assign o_busy      = (state_q == BUSY);

endmodule
